z_decode_stage: RTL and testbench
=================================

// Module: z_decode_stage
// PURPOSE
//  Registered, handshaked instruction-decode stage; successor to the combinational z_decoder.
//  Decodes one INS_W-bit MIPS-style instruction per transfer into the control bundle and field
//  outputs, and holds them in an output register with 1-cycle latency.
//  Detects load-use hazards against the instruction held in the output register and inserts one
//  bubble. Also counts inserted stalls. Sits between fetch and register-read/execute.
// PARAMETERS
//  INS_W   32  instruction width; opcode = ins[INS_W-1 -: 6], fields laid out MIPS-style from bit 0
//  RA_W    5   register-address width (rs/rt/rd)
//  SHAMT_W 5   shift-amount width
//  CNT_W   8   stall-counter width (saturating)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        synchronous flush; squashes the output register
//  in_valid   in   1        ins_in valid
//  in_ready   out  1        stage accepts ins_in this cycle
//  ins_in     in   INS_W    instruction word
//  out_valid  out  1        decoded bundle valid
//  out_ready  in   1        downstream accepts bundle
//  jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_sel, reg_write  out 1  controls
//  shamt      out  SHAMT_W  ins[10:6]
//  rs, rt, rd out  RA_W     ins[25:21], ins[20:16], ins[15:11]
//  imm        out  16       ins[15:0]
//  stall_cnt  out  CNT_W    bubbles inserted since reset
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0; all controls, fields, imm, stall_cnt = 0.
//  Decode table (opcode -> asserted controls; all others 0):
//   000000 R-type: reg_dest, reg_write
//   000010 J:      jump
//   000100 BEQ:    branch, sign_ext
//   100011 LW:     mem_to_reg, sign_ext, alu_sel, reg_write
//   101011 SW:     mem_write, sign_ext, alu_sel
//   001000 ADDI:   sign_ext, alu_sel, reg_write
//   001100 ANDI / 001101 ORI: alu_sel, reg_write (zero-extend)
//   other: all controls 0 (NOP); see CONFIGURATION.
//  Fields are passed through for every opcode.
//  Hazard: haz = out_valid & mem_to_reg & (rt!=0) & (ins_in.rs==rt |
//   (ins_in is R-type/BEQ/SW & ins_in.rt==rt)).
//  in_ready = (~out_valid | out_ready) & ~haz & ~flush.
//  Transfer = in_valid & in_ready. On the next edge, register the decoded bundle and set
//   out_valid=1. Latency is exactly 1 cycle.
//  Pop (out_valid & out_ready) with no transfer -> out_valid=0 next edge; bundle holds last value.
//  Bubble: in_valid & haz & out_ready -> LW leaves, out_valid=0 next cycle, stall_cnt+1
//   (saturates at all-ones). The following cycle haz=0 and the instruction is accepted.
//   One-cycle stall total.
//  out_ready=0 with haz: hold everything; stall_cnt not incremented.
//  Output stable: while out_valid & ~out_ready, bundle and out_valid do not change.
//  flush=1: out_valid=0 next edge; no transfer that cycle; flush dominates transfer and bubble.
//   stall_cnt keeps its value.
//  Reset asserted mid-transfer: immediate clear; no partial bundle survives.
// CONFIGURATION
//  DEC_ILLEGAL_EN defined: extra port illegal (out, 1), registered with the bundle.
//   Set for an opcode outside the table; controls 0; reset 0.
//  Not defined: no illegal port; unknown opcodes decode silently as NOP.
// TESTING
//  1 reset: rst_n=0 mid-cycle -> out_valid=0, stall_cnt=0 immediately, no clk edge needed.
//  2 ins_in=32'h10221821 (BEQ rs=1 rt=2), out_ready=1 -> next cycle: out_valid=1, branch=1,
//    sign_ext=1, others 0, rs=1, rt=2, imm=16'h1821.
//  3 LW 32'h8C430000 (rt=3), then ADD 32'h00632020 (rs=3) back-to-back ->
//    in_ready=0 one cycle; out_valid 1,0,1; stall_cnt=1.
//  4 out_ready=0 for 3 cycles with a valid bundle -> bundle stable, in_ready=0, stall_cnt unchanged.
//  5 flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, instruction not accepted.
//  6 opcode 111111 -> controls all 0. Macro defined: illegal=1; LW next -> illegal=0.
//    Plus 2^CNT_W+2 forced hazards -> stall_cnt saturates at all-ones.

Source files
------------

// File: rtl/z_decode_stage.sv
// ----------------------------------------------------------------------------
// z_decode_stage
//   Registered, handshaked instruction-decode stage (1-cycle latency).
//   Decodes one MIPS-style instruction per transfer into a control bundle plus
//   pass-through fields, holds it in an output register, inserts a single
//   bubble on a load-use hazard against the held instruction, and counts the
//   bubbles it inserts (saturating).
//
//   Optional feature macro: DEC_ILLEGAL_EN
//     defined   : adds output 'illegal', set for opcodes outside the table.
//     undefined : no 'illegal' port; unknown opcodes decode as NOP.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 squashes the output register, blocks acceptance
//   in_valid/in_ready     input handshake, ins_in = instruction word
//   out_valid/out_ready   output handshake for the decoded bundle
//   jump .. reg_write     control bundle
//   shamt, rs, rt, rd,imm instruction fields
//   illegal               (DEC_ILLEGAL_EN only) unknown-opcode flag
//   stall_cnt             bubbles inserted since reset, saturating
// ----------------------------------------------------------------------------
module z_decode_stage #(
   parameter int INS_W   = 32,
   parameter int RA_W    = 5,
   parameter int SHAMT_W = 5,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INS_W-1:0]   ins_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               jump,
   output logic               branch,
   output logic               mem_to_reg,
   output logic               sign_ext,
   output logic               reg_dest,
   output logic               mem_write,
   output logic               alu_sel,
   output logic               reg_write,
   output logic [SHAMT_W-1:0] shamt,
   output logic [RA_W-1:0]    rs,
   output logic [RA_W-1:0]    rt,
   output logic [RA_W-1:0]    rd,
   output logic [15:0]        imm,
`ifdef DEC_ILLEGAL_EN
   output logic               illegal,
`endif
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + 1'b1;
   endfunction

   // ---- stage p0: combinational decode of the incoming instruction ----
   logic [5:0]      op_p0;
   logic [RA_W-1:0] rs_p0;
   logic [RA_W-1:0] rt_p0;
   // ctrl order: {jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_sel, reg_write}
   logic [7:0]      ctrl_p0;
`ifdef DEC_ILLEGAL_EN
   logic            illegal_p0;
`endif

   assign op_p0 = ins_in[INS_W-1 -: 6];
   assign rs_p0 = ins_in[21 +: RA_W];
   assign rt_p0 = ins_in[16 +: RA_W];

   always_comb begin
      ctrl_p0 = 8'b0;
`ifdef DEC_ILLEGAL_EN
      illegal_p0 = 1'b0;
`endif
      case (op_p0)
         OP_R:    ctrl_p0 = 8'b0000_1001;
         OP_J:    ctrl_p0 = 8'b1000_0000;
         OP_BEQ:  ctrl_p0 = 8'b0101_0000;
         OP_LW:   ctrl_p0 = 8'b0011_0011;
         OP_SW:   ctrl_p0 = 8'b0001_0110;
         OP_ADDI: ctrl_p0 = 8'b0001_0011;
         OP_ANDI: ctrl_p0 = 8'b0000_0011;
         OP_ORI:  ctrl_p0 = 8'b0000_0011;
         default: begin
`ifdef DEC_ILLEGAL_EN
            illegal_p0 = 1'b1;
`endif
         end
      endcase
   end

   // Load-use hazard: the held LW writes rt, and the incoming instruction reads
   // it as rs, or as rt for the formats that actually read rt as a source.
   logic reads_rt_p0;
   logic haz;
   logic xfer;
   logic pop;
   logic bubble;

   assign reads_rt_p0 = (op_p0 == OP_R) || (op_p0 == OP_BEQ) || (op_p0 == OP_SW);
   assign haz = out_valid & mem_to_reg & (rt != '0) &
                ((rs_p0 == rt) | (reads_rt_p0 & (rt_p0 == rt)));
   assign in_ready = (~out_valid | out_ready) & ~haz & ~flush;
   assign xfer     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   assign bubble   = in_valid & haz & out_ready & ~flush;

   // ---- stage p1: output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         jump       <= 1'b0;
         branch     <= 1'b0;
         mem_to_reg <= 1'b0;
         sign_ext   <= 1'b0;
         reg_dest   <= 1'b0;
         mem_write  <= 1'b0;
         alu_sel    <= 1'b0;
         reg_write  <= 1'b0;
         shamt      <= '0;
         rs         <= '0;
         rt         <= '0;
         rd         <= '0;
         imm        <= '0;
`ifdef DEC_ILLEGAL_EN
         illegal    <= 1'b0;
`endif
         stall_cnt  <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (xfer) begin
            out_valid <= 1'b1;
            {jump, branch, mem_to_reg, sign_ext,
             reg_dest, mem_write, alu_sel, reg_write} <= ctrl_p0;
            shamt <= ins_in[6 +: SHAMT_W];
            rs    <= rs_p0;
            rt    <= rt_p0;
            rd    <= ins_in[11 +: RA_W];
            imm   <= ins_in[15:0];
`ifdef DEC_ILLEGAL_EN
            illegal <= illegal_p0;
`endif
         end else if (pop) begin
            // Bundle fields keep their last value; only validity drops.
            out_valid <= 1'b0;
         end
         if (bubble) stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_z_decode_stage.sv
module tb_z_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ins_in;
   logic        out_valid;
   logic        out_ready;
   logic        jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_sel, reg_write;
   logic [4:0]  shamt, rs, rt, rd;
   logic [15:0] imm;
   logic [7:0]  stall_cnt;
   logic        ill_w;

   always #5 clk = ~clk;

   z_decode_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .ins_in(ins_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .jump(jump), .branch(branch), .mem_to_reg(mem_to_reg), .sign_ext(sign_ext),
      .reg_dest(reg_dest), .mem_write(mem_write), .alu_sel(alu_sel), .reg_write(reg_write),
      .shamt(shamt), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
`ifdef DEC_ILLEGAL_EN
      .illegal(ill_w),
`endif
      .stall_cnt(stall_cnt)
   );

`ifndef DEC_ILLEGAL_EN
   assign ill_w = 1'b0;
`endif

   typedef struct {
      logic [7:0]  ctrl;
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_stall = 0;
   int   w;
   logic ov;

   function automatic exp_t mk(input logic [7:0] c, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] d, input logic [4:0] s, input logic [15:0] i,
                               input logic il);
      exp_t r;
      r.ctrl = c; r.rs = a; r.rt = b; r.rd = d; r.sh = s; r.imm = i;
`ifdef DEC_ILLEGAL_EN
      r.ill = il;
`else
      r.ill = 1'b0 & il;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every bundle popped downstream must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out: bundle rs=%0d rt=%0d imm=%h with empty scoreboard", rs, rt, imm);
         end else begin
            me = sb.pop_front();
            chk("bundle",
                {19'd0, ill_w, jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_sel,
                 reg_write, rs, rt, rd, shamt, imm},
                {19'd0, me.ill, me.ctrl, me.rs, me.rt, me.rd, me.sh, me.imm});
         end
      end
   end

   task automatic send(input logic [31:0] ins, input exp_t e, output int waits, output logic ov_acc);
      bit done;
      in_valid = 1'b1;
      ins_in   = ins;
      waits    = 0;
      ov_acc   = 1'b0;
      done     = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            ov_acc = out_valid;
            done = 1;
         end else begin
            waits++;
            if (k < 39) @(posedge clk);
         end
      end
      if (!done) begin
         n_checks++;
         $display("FAIL send_timeout: ins %h not accepted, waited %0d cycles", ins, waits);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic bump_stall();
      if (exp_stall < 255) exp_stall++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ins_in = 32'h0;
      #12;
      // 1: reset state
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_stall_cnt", stall_cnt, 8'd0);
      chk("rst_fields", {rs, rt, rd, shamt, imm}, 36'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      idle(1);

      // 2: BEQ, latency 1
      send(32'h10221821, mk(8'b0101_0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1821, 1'b0), w, ov);
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;

      // decode table, back-to-back
      send(32'h08000010, mk(8'b1000_0000, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0010, 1'b0), w, ov);
      send(32'hAC450004, mk(8'b0001_0110, 5'd2, 5'd5, 5'd0, 5'd0, 16'h0004, 1'b0), w, ov);
      chk("b2b_wait_sw", w, 0);
      send(32'h20A6FFFF, mk(8'b0001_0011, 5'd5, 5'd6, 5'd31, 5'd31, 16'hFFFF, 1'b0), w, ov);
      send(32'h34E70F0F, mk(8'b0000_0011, 5'd7, 5'd7, 5'd1, 5'd28, 16'h0F0F, 1'b0), w, ov);
      send(32'h31080001, mk(8'b0000_0011, 5'd8, 5'd8, 5'd0, 5'd0, 16'h0001, 1'b0), w, ov);
      send(32'h00021140, mk(8'b0000_1001, 5'd0, 5'd2, 5'd2, 5'd5, 16'h1140, 1'b0), w, ov);
      chk("b2b_wait_sll", w, 0);

      // 3: LW then dependent ADD
      send(32'h8C430000, mk(8'b0011_0011, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
      send(32'h00632020, mk(8'b0000_1001, 5'd3, 5'd3, 5'd4, 5'd0, 16'h2020, 1'b0), w, ov);
      bump_stall();
      chk("luse_wait", w, 1);
      chk("luse_bubble_valid", ov, 1'b0);
      chk("luse_stall_cnt", stall_cnt, exp_stall);

      // rt-only dependence: SW reads rt, ADDI does not
      send(32'h8C430000, mk(8'b0011_0011, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
      send(32'hAC230000, mk(8'b0001_0110, 5'd1, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
      bump_stall();
      chk("sw_rt_wait", w, 1);
      send(32'h8C430000, mk(8'b0011_0011, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
      send(32'h20230000, mk(8'b0001_0011, 5'd1, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
      chk("addi_rt_wait", w, 0);
      // LW to r0 never stalls
      send(32'h8C400000, mk(8'b0011_0011, 5'd2, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
      send(32'h00001020, mk(8'b0000_1001, 5'd0, 5'd0, 5'd2, 5'd0, 16'h1020, 1'b0), w, ov);
      chk("r0_wait", w, 0);
      chk("r0_stall_cnt", stall_cnt, exp_stall);

      // 4: downstream stall with a pending hazard
      idle(1);
      out_ready = 1'b0;
      send(32'h8C430000, mk(8'b0011_0011, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
      in_valid = 1'b1;
      ins_in   = 32'h00632020;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_bundle", {out_valid, mem_to_reg, rs, rt, imm}, {1'b1, 1'b1, 5'd2, 5'd3, 16'h0000});
         chk("hold_stall_cnt", stall_cnt, exp_stall);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(32'h00632020, mk(8'b0000_1001, 5'd3, 5'd3, 5'd4, 5'd0, 16'h2020, 1'b0), w, ov);
      bump_stall();
      chk("hold_release_wait", w, 1);
      chk("hold_stall_after", stall_cnt, exp_stall);

      // 5: flush with a held bundle and a valid input
      idle(1);
      out_ready = 1'b0;
      send(32'h10221821, mk(8'b0101_0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1821, 1'b0), w, ov);
      flush = 1'b1; in_valid = 1'b1; ins_in = 32'h08000010;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      if (sb.size() > 0) void'(sb.pop_back());
      @(negedge clk);
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_stall_cnt", stall_cnt, exp_stall);
      out_ready = 1'b1;
      idle(2);
      @(negedge clk);
      chk("flush_not_accepted", out_valid, 1'b0);
      @(posedge clk); #1;

      // 6: unknown opcode, then LW
      send(32'hFC000000, mk(8'b0000_0000, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1), w, ov);
      send(32'h8C430000, mk(8'b0011_0011, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);

      // counter saturation: 2^8+2 forced hazards
      for (int k = 0; k < 258; k++) begin
         send(32'h8C430000, mk(8'b0011_0011, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0000, 1'b0), w, ov);
         send(32'h00632020, mk(8'b0000_1001, 5'd3, 5'd3, 5'd4, 5'd0, 16'h2020, 1'b0), w, ov);
         bump_stall();
         if (w != 1) chk("sat_loop_wait", w, 1);
      end
      chk("sat_stall_cnt", stall_cnt, 8'hFF);

      // reset asserted mid-cycle with a held bundle
      idle(1);
      out_ready = 1'b0;
      send(32'h10221821, mk(8'b0101_0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1821, 1'b0), w, ov);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 1'b0);
      chk("async_rst_stall_cnt", stall_cnt, 8'd0);
      chk("async_rst_fields", {branch, rs, rt, imm}, 32'd0);
      sb.delete();
      #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(2);
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 1'b0);
      chk("sb_drain", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
